// File: rtl/spi_return_tx_if.sv
// Push-side bundle of the SPI return-path transmitter.
// The FPGA logic feeding readback bytes takes the master side.
`timescale 1ns/1ps
interface spi_return_tx_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    return_wrdata;
  logic          return_push;
  logic          return_full;
  logic [CW-1:0] return_count;
  logic          underrun;
  logic          overflow;

  modport master (
    output return_wrdata, return_push,
    input  return_full, return_count, underrun, overflow
  );

  modport slave (
    input  return_wrdata, return_push,
    output return_full, return_count, underrun, overflow
  );
endinterface

// File: rtl/spi_return_tx.sv
// SPI return-path transmitter: a small byte FIFO filled from the FPGA side,
// serialized MSB-first on spi_miso (mode 0) while the CPU clocks the bus.
// spi_clk/spi_cs are oversampled in the clk domain through synchronizers.
`timescale 1ns/1ps
module spi_return_tx #(
  parameter int         DEPTH       = 4,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          spi_clk,
  input  logic          spi_cs,
  output logic          spi_miso,
  output logic          spi_miso_oe,
  spi_return_tx_if.slave ret
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // Lockout settle counter must reach SYNC_STAGES+1.
  localparam int LW = $clog2(SYNC_STAGES + 2);

  typedef enum logic [1:0] {
    ST_LOCKOUT,
    ST_IDLE,
    ST_ACTIVE
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q;
  logic                   sclk_hist_q, cs_hist_q;
  logic [LW-1:0]          lock_cnt_q;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic lock_settled;
  logic load;
  logic fifo_empty, fifo_full;
  logic pop, push_ok, underrun_evt, overflow_evt;

  assign sclk_lvl  = sclk_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_lvl & ~sclk_hist_q;
  assign sclk_fall = ~sclk_lvl & sclk_hist_q;
  assign cs_lvl    = cs_sync_q[SYNC_STAGES-1];
  assign cs_rise   = cs_lvl & ~cs_hist_q;
  assign cs_fall   = ~cs_lvl & cs_hist_q;

  // Synchronizer chains plus one history flop each for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      sclk_hist_q <= sclk_lvl;
      cs_hist_q   <= cs_lvl;
    end
  end

  // After reset the synchronizers read 0 until refilled from the pins, so
  // LOCKOUT waits for the chain to settle before trusting a low CS.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_cnt_q <= '0;
    end else if (state_q == ST_LOCKOUT && !lock_settled) begin
      lock_cnt_q <= lock_cnt_q + LW'(1);
    end
  end

  assign lock_settled = (lock_cnt_q == LW'(SYNC_STAGES + 1));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOCKOUT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and byte-load request. A spi_clk fall arriving together
  // with the CS fall ends the transfer without loading another byte.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_LOCKOUT: begin
        if (lock_settled && !cs_lvl) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (cs_rise) begin
          state_d = ST_ACTIVE;
          load    = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (cs_fall) begin
          state_d = ST_IDLE;
        end else if (sclk_fall && bit_cnt_q == 3'd0) begin
          load = 1'b1;
        end
      end
      default: state_d = ST_LOCKOUT;
    endcase
  end

  assign fifo_empty   = (count_q == '0);
  assign fifo_full    = (count_q == CW'(DEPTH));
  assign pop          = load & ~fifo_empty;
  assign underrun_evt = load & fifo_empty;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok      = ret.return_push & (~fifo_full | pop);
  assign overflow_evt = ret.return_push & fifo_full & ~pop;

  // Bit counter, shift register and occupancy next-state.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    count_d   = count_q;

    if (state_q == ST_ACTIVE && !cs_fall) begin
      if (sclk_rise) bit_cnt_d = bit_cnt_q + 3'd1;
    end else begin
      bit_cnt_d = 3'd0;
    end

    if (load) begin
      shift_d = pop ? mem_q[rd_ptr_q] : IDLE_BYTE;
    end else if (state_q == ST_ACTIVE && !cs_fall && sclk_fall && bit_cnt_q != 3'd0) begin
      shift_d = {shift_q[6:0], 1'b0};
    end

    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Datapath registers: pointers, occupancy, bit counter, shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
    end else begin
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      count_q   <= count_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // FIFO storage; contents need no reset since the pointers are cleared.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem_q[wr_ptr_q] <= ret.return_wrdata;
    end
  end

  assign spi_miso_oe      = (state_q == ST_ACTIVE);
  assign spi_miso         = (state_q == ST_ACTIVE) & shift_q[7];
  assign ret.return_full  = fifo_full;
  assign ret.return_count = count_q;
  assign ret.underrun     = underrun_evt & ~rst;
  assign ret.overflow     = overflow_evt & ~rst;

endmodule

// File: tb/tb_spi_return_tx.sv
// Directed bench for spi_return_tx: push-side vector table plus mode-0
// SPI master sequences for transfer, underrun, abort and reset corners.
`timescale 1ns/1ps
module tb_spi_return_tx;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic spi_clk;
  logic spi_cs;
  logic spi_miso;
  logic spi_miso_oe;

  spi_return_tx_if #(.DEPTH(DEPTH)) rif ();

  spi_return_tx #(
    .DEPTH      (DEPTH),
    .IDLE_BYTE  (8'hFF),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .spi_clk    (spi_clk),
    .spi_cs     (spi_cs),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .ret        (rif.slave)
  );

  always #16 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int und_cnt  = 0;
  int ovf_cnt  = 0;

  // Count event pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (rif.underrun === 1'b1) und_cnt <= und_cnt + 1;
    if (rif.overflow === 1'b1) ovf_cnt <= ovf_cnt + 1;
  end

  typedef struct {
    logic       push;
    logic [7:0] data;
    logic       exp_ovf;
    logic [2:0] exp_count;
    logic       exp_full;
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] exp_bytes [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] d);
    rif.return_wrdata = d;
    rif.return_push   = 1'b1;
    tick(1);
    rif.return_push   = 1'b0;
    $display("push: 0x%02h count now pending", d);
  endtask

  task automatic cs_start();
    spi_cs = 1'b1;
    tick(6);
  endtask

  // One byte as a mode-0 master at clk/8; samples MISO on the rising edge.
  // On the last byte CS drops together with the final falling edge.
  task automatic shift_byte(input bit last, output logic [7:0] b, output bit oe_ok);
    oe_ok = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      spi_clk = 1'b1;
      b[i] = spi_miso;
      if (spi_miso_oe !== 1'b1) oe_ok = 1'b0;
      tick(4);
      spi_clk = 1'b0;
      if (last && i == 0) spi_cs = 1'b0;
      tick(4);
    end
    if (last) tick(2);
    $display("xfer: read 0x%02h", b);
  endtask

  logic [7:0] rb;
  bit         ok;
  int         u0, o0;

  initial begin
    // Push-side vectors: five pushes into a 4-deep FIFO, then an idle cycle.
    vecs[0] = '{1'b1, 8'h01, 1'b0, 3'd1, 1'b0};
    vecs[1] = '{1'b1, 8'h02, 1'b0, 3'd2, 1'b0};
    vecs[2] = '{1'b1, 8'h03, 1'b0, 3'd3, 1'b0};
    vecs[3] = '{1'b1, 8'h04, 1'b0, 3'd4, 1'b1};
    vecs[4] = '{1'b1, 8'h05, 1'b1, 3'd4, 1'b1};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 3'd4, 1'b1};
    exp_bytes[0] = 8'h01;
    exp_bytes[1] = 8'h02;
    exp_bytes[2] = 8'h03;
    exp_bytes[3] = 8'h04;

    rst = 1'b1;
    spi_clk = 1'b0;
    spi_cs = 1'b0;
    rif.return_push = 1'b0;
    rif.return_wrdata = 8'h00;
    tick(3);

    // Reset values.
    check("rst_miso", spi_miso, 0);
    check("rst_oe", spi_miso_oe, 0);
    check("rst_underrun", rif.underrun, 0);
    check("rst_overflow", rif.overflow, 0);
    check("rst_full", rif.return_full, 0);
    check("rst_count", rif.return_count, 0);
    rst = 1'b0;
    tick(4);

    // Basic transfer: A5 then 3C, count 2->1->0, no underrun.
    u0 = und_cnt;
    push_byte(8'hA5);
    push_byte(8'h3C);
    check("basic_count2", rif.return_count, 2);
    cs_start();
    check("basic_count1", rif.return_count, 1);
    shift_byte(1'b0, rb, ok);
    check("basic_byte0", rb, 8'hA5);
    check("basic_count0", rif.return_count, 0);
    shift_byte(1'b1, rb, ok);
    check("basic_byte1", rb, 8'h3C);
    check("basic_no_underrun", und_cnt - u0, 0);
    tick(2);

    // Underrun: empty FIFO reads IDLE_BYTE, one underrun pulse.
    u0 = und_cnt;
    cs_start();
    check("undr_oe_active", spi_miso_oe, 1);
    check("undr_pulse_at_load", und_cnt - u0, 1);
    shift_byte(1'b1, rb, ok);
    check("undr_byte", rb, 8'hFF);
    check("undr_oe_throughout", ok, 1);
    check("undr_oe_after", spi_miso_oe, 0);
    check("undr_pulse_once", und_cnt - u0, 1);

    // Overflow: vector table on the push side.
    o0 = ovf_cnt;
    for (int v = 0; v < 6; v++) begin
      rif.return_push   = vecs[v].push;
      rif.return_wrdata = vecs[v].data;
      #1;
      check($sformatf("vec%0d_overflow", v), rif.overflow, vecs[v].exp_ovf);
      tick(1);
      rif.return_push = 1'b0;
      check($sformatf("vec%0d_count", v), rif.return_count, vecs[v].exp_count);
      check($sformatf("vec%0d_full", v), rif.return_full, vecs[v].exp_full);
      $display("vec%0d: push=%0b data=0x%02h count=%0d", v, vecs[v].push, vecs[v].data, rif.return_count);
    end
    check("ovf_pulse_count", ovf_cnt - o0, 1);
    cs_start();
    for (int k = 0; k < 4; k++) begin
      shift_byte(k == 3, rb, ok);
      check($sformatf("ovf_byte%0d", k), rb, exp_bytes[k]);
    end
    check("ovf_drained", rif.return_count, 0);

    // CS abort after three rises: F0 is lost, 0F follows from bit 0.
    push_byte(8'hF0);
    push_byte(8'h0F);
    cs_start();
    for (int r = 0; r < 3; r++) begin
      spi_clk = 1'b1;
      tick(4);
      spi_clk = 1'b0;
      if (r == 2) spi_cs = 1'b0;
      tick(4);
    end
    tick(2);
    check("abort_oe_off", spi_miso_oe, 0);
    check("abort_count", rif.return_count, 1);
    cs_start();
    shift_byte(1'b1, rb, ok);
    check("abort_next_byte", rb, 8'h0F);

    // Full FIFO, push coincides with the entry load pop.
    o0 = ovf_cnt;
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    push_byte(8'h44);
    check("sim_full_before", rif.return_full, 1);
    spi_cs = 1'b1;
    tick(2);
    rif.return_wrdata = 8'h77;
    rif.return_push   = 1'b1;
    #1;
    check("sim_full_no_overflow", rif.overflow, 0);
    tick(1);
    rif.return_push = 1'b0;
    check("sim_full_count", rif.return_count, 4);
    tick(3);
    exp_bytes[0] = 8'h11;
    exp_bytes[1] = 8'h22;
    exp_bytes[2] = 8'h33;
    exp_bytes[3] = 8'h44;
    for (int k = 0; k < 5; k++) begin
      shift_byte(k == 4, rb, ok);
      check($sformatf("sim_full_byte%0d", k), rb, (k == 4) ? 8'h77 : exp_bytes[k]);
    end
    check("sim_full_ovf_none", ovf_cnt - o0, 0);

    // Empty FIFO, push coincides with the entry load: FF then the push.
    spi_cs = 1'b1;
    tick(2);
    rif.return_wrdata = 8'hAB;
    rif.return_push   = 1'b1;
    #1;
    check("sim_empty_underrun", rif.underrun, 1);
    check("sim_empty_no_overflow", rif.overflow, 0);
    tick(1);
    rif.return_push = 1'b0;
    check("sim_empty_count", rif.return_count, 1);
    tick(3);
    shift_byte(1'b0, rb, ok);
    check("sim_empty_byte0", rb, 8'hFF);
    shift_byte(1'b1, rb, ok);
    check("sim_empty_byte1", rb, 8'hAB);

    // Reset mid-byte with CS held high: locked out until CS cycles.
    u0 = und_cnt;
    push_byte(8'h55);
    cs_start();
    for (int r = 0; r < 2; r++) begin
      spi_clk = 1'b1;
      tick(4);
      spi_clk = 1'b0;
      tick(4);
    end
    spi_clk = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("rmid_oe", spi_miso_oe, 0);
    check("rmid_miso", spi_miso, 0);
    check("rmid_count", rif.return_count, 0);
    for (int r = 0; r < 3; r++) begin
      spi_clk = 1'b0;
      tick(4);
      spi_clk = 1'b1;
      tick(4);
    end
    check("rmid_locked_oe", spi_miso_oe, 0);
    spi_clk = 1'b0;
    spi_cs  = 1'b0;
    tick(6);
    cs_start();
    check("rmid_reentry_oe", spi_miso_oe, 1);
    shift_byte(1'b1, rb, ok);
    check("rmid_byte", rb, 8'hFF);
    check("rmid_underrun", und_cnt - u0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
